// File: rtl/ram_copy_engine.sv
// ram_copy_engine: drives one port of the flip-flop RAM to perform block copy
// (read-then-write per word, ascending) and block fill, then pulses o_done.
//
// Handshake: a command transfers on the rising edge where i_cmd_valid and
// o_cmd_ready are both high. o_cmd_ready is high only in IDLE. A command
// presented while busy is neither accepted nor remembered, so the issuer must
// keep it asserted until it sees o_cmd_ready.
module ram_copy_engine #(
  parameter  int DATA    = 32,
  parameter  int BYTE    = DATA,
  parameter  int DEPTH   = 4,
  parameter  int RLAT    = 0,
  localparam int BYTESEL = DATA / BYTE,
  localparam int ADDR    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_fill,
  input  logic [ADDR-1:0]    i_cmd_src,
  input  logic [ADDR-1:0]    i_cmd_dst,
  input  logic [ADDR:0]      i_cmd_len,
  input  logic [DATA-1:0]    i_cmd_pattern,
  output logic               o_busy,
  output logic               o_done,
  output logic [BYTESEL-1:0] o_ram_en,
  output logic               o_ram_rw_,
  output logic [ADDR-1:0]    o_ram_addr,
  output logic [DATA-1:0]    o_ram_wdata,
  input  logic [DATA-1:0]    i_ram_rdata,
  output logic [1:0]         o_state
);

  localparam int LEN_W = ADDR + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_i;
  logic [ADDR-1:0]    r_src;
  logic [ADDR-1:0]    r_dst;
  logic [LEN_W-1:0]   r_len;
  logic               r_fill;
  logic [DATA-1:0]    r_pattern;
  logic [DATA-1:0]    r_hold;
  logic [BYTESEL-1:0] r_ram_en;
  logic               r_ram_rw_;
  logic [ADDR-1:0]    r_ram_addr;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_done;

  logic [LEN_W-1:0]   w_i_nxt;
  logic               w_more;
  logic [ADDR-1:0]    w_src_nxt;
  logic [ADDR-1:0]    w_dst_cur;
  logic [ADDR-1:0]    w_dst_nxt;
  logic [DATA-1:0]    w_wdata;

  // Word index arithmetic; address sums wrap modulo 2^ADDR by truncation.
  assign w_i_nxt   = r_i + LEN_W'(1);
  assign w_more    = (w_i_nxt < r_len);
  assign w_src_nxt = r_src + w_i_nxt[ADDR-1:0];
  assign w_dst_cur = r_dst + r_i[ADDR-1:0];
  assign w_dst_nxt = r_dst + w_i_nxt[ADDR-1:0];

  // Control FSM: port drive and status flags are registered together with the
  // next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_fill      <= 1'b0;
      r_pattern   <= '0;
      r_hold      <= '0;
      r_ram_en    <= '0;
      r_ram_rw_   <= 1'b1;
      r_ram_addr  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_src       <= i_cmd_src;
            r_dst       <= i_cmd_dst;
            r_len       <= i_cmd_len;
            r_fill      <= i_cmd_fill;
            r_pattern   <= i_cmd_pattern;
            r_i         <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (i_cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (i_cmd_fill) begin
              r_state    <= S_WRITE;
              r_ram_en   <= {BYTESEL{1'b1}};
              r_ram_rw_  <= 1'b0;
              r_ram_addr <= i_cmd_dst;
            end else begin
              r_state    <= S_READ;
              r_ram_en   <= {BYTESEL{1'b1}};
              r_ram_rw_  <= 1'b1;
              r_ram_addr <= i_cmd_src;
            end
          end
        end
        S_READ: begin
          // A combinational-read RAM only holds the word during READ, so keep it.
          if (RLAT == 0) begin
            r_hold <= i_ram_rdata;
          end
          r_state    <= S_WRITE;
          r_ram_rw_  <= 1'b0;
          r_ram_addr <= w_dst_cur;
        end
        S_WRITE: begin
          if (w_more) begin
            r_i <= w_i_nxt;
            if (r_fill) begin
              r_ram_addr <= w_dst_nxt;
            end else begin
              r_state    <= S_READ;
              r_ram_rw_  <= 1'b1;
              r_ram_addr <= w_src_nxt;
            end
          end else begin
            r_state    <= S_DONE;
            r_ram_en   <= '0;
            r_ram_rw_  <= 1'b1;
            r_ram_addr <= '0;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Write data source: fill pattern, held read word, or the RAM's output register.
  always_comb begin
    w_wdata = '0;
    if (r_state == S_WRITE) begin
      if (r_fill) begin
        w_wdata = r_pattern;
      end else if (RLAT == 1) begin
        w_wdata = i_ram_rdata;
      end else begin
        w_wdata = r_hold;
      end
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ram_en    = r_ram_en;
  assign o_ram_rw_   = r_ram_rw_;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = w_wdata;
  assign o_state     = r_state;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: two instances (combinational-read and registered-read
// RAM) share one command stream; each has its own RAM model and scoreboard.
module tb_ram_copy_engine;

  localparam int W = 68;  // {cycle[31:0], rw_, addr[2:0], wdata[31:0]}

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_fill;
  logic [2:0]  cmd_src;
  logic [2:0]  cmd_dst;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_pattern;

  logic        rdy0, bsy0, dn0, rw0, rdy1, bsy1, dn1, rw1;
  logic [0:0]  en0, en1;
  logic [2:0]  addr0, addr1;
  logic [31:0] wd0, wd1, rd0, rd1;
  logic [1:0]  st0, st1;

  logic [31:0] mem0 [8];
  logic [31:0] mem1 [8];
  logic [31:0] init_mem [8];
  logic [31:0] model [8];
  logic        load;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           done_q0[$];
  int           done_q1[$];

  int cyc;
  int checks;
  int failures;
  bit started;

  ram_copy_engine #(.DATA(32), .DEPTH(8), .RLAT(0)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy0),
    .i_cmd_fill(cmd_fill), .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst),
    .i_cmd_len(cmd_len), .i_cmd_pattern(cmd_pattern), .o_busy(bsy0), .o_done(dn0),
    .o_ram_en(en0), .o_ram_rw_(rw0), .o_ram_addr(addr0), .o_ram_wdata(wd0),
    .i_ram_rdata(rd0), .o_state(st0));

  ram_copy_engine #(.DATA(32), .DEPTH(8), .RLAT(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy1),
    .i_cmd_fill(cmd_fill), .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst),
    .i_cmd_len(cmd_len), .i_cmd_pattern(cmd_pattern), .o_busy(bsy1), .o_done(dn1),
    .o_ram_en(en1), .o_ram_rw_(rw1), .o_ram_addr(addr1), .o_ram_wdata(wd1),
    .i_ram_rdata(rd1), .o_state(st1));

  // ---------------- clock / reset / RAM models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rd0 = mem0[addr0];

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++) mem0[k] <= init_mem[k];
    end else if (en0 == 1'b1 && !rw0) begin
      mem0[addr0] <= wd0;
    end
  end

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++) mem1[k] <= init_mem[k];
    end else begin
      if (en1 == 1'b1 && rw1) rd1 <= mem1[addr1];
      if (en1 == 1'b1 && !rw1) mem1[addr1] <= wd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic push_acc(input int c, input bit rw, input int a, input logic [31:0] d);
    logic [W-1:0] e;
    e = {32'(c), rw, 3'(a), d};
    exp_q0.push_back(e);
    exp_q1.push_back(e);
  endtask

  // Reference model: expected RAM access sequence and timing of one command,
  // applying its effect to the model memory. nacc < 0 means run to completion;
  // otherwise only the first nacc accesses happen (command cut by reset).
  task automatic push_cmd(input bit fill, input int src, input int dst, input int len,
                          input logic [31:0] pat, input int a, input int nacc);
    int n;
    int s;
    int d;
    n = 0;
    if (len == 0) begin
      if (nacc < 0) begin done_q0.push_back(a + 1); done_q1.push_back(a + 1); end
      return;
    end
    for (int i = 0; i < len; i++) begin
      s = (src + i) % 8;
      d = (dst + i) % 8;
      if (fill) begin
        if (nacc >= 0 && n >= nacc) break;
        push_acc(a + 1 + i, 1'b0, d, pat);
        model[d] = pat;
        n++;
      end else begin
        if (nacc >= 0 && n >= nacc) break;
        push_acc(a + 1 + 2 * i, 1'b1, s, 32'h0);
        n++;
        if (nacc >= 0 && n >= nacc) break;
        push_acc(a + 2 + 2 * i, 1'b0, d, model[s]);
        model[d] = model[s];
        n++;
      end
    end
    if (nacc < 0) begin
      done_q0.push_back(a + 1 + (fill ? len : 2 * len));
      done_q1.push_back(a + 1 + (fill ? len : 2 * len));
    end
  endtask

  // Driver: wait for ready, present one command, record its accept cycle.
  task automatic issue(input bit fill, input int src, input int dst, input int len,
                       input logic [31:0] pat, input int nacc, output int a);
    int g;
    g = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1)) begin
      g++;
      if (g > 100) begin
        failures++;
        checks++;
        $display("FAIL ready_timeout cyc=%0d ready0=%0d ready1=%0d required=1", cyc, rdy0, rdy1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "ready timeout");
      end
      @(negedge clk);
    end
    cmd_valid   = 1'b1;
    cmd_fill    = fill;
    cmd_src     = 3'(src);
    cmd_dst     = 3'(dst);
    cmd_len     = 4'(len);
    cmd_pattern = pat;
    a = cyc;
    push_cmd(fill, src, dst, len, pat, a, nacc);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || done_q0.size() != 0 ||
            done_q1.size() != 0 || !rdy0 || !rdy1) && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 300) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d/%0d done=%0d/%0d required=0",
               exp_q0.size(), exp_q1.size(), done_q0.size(), done_q1.size());
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready0"}, 32'(rdy0), 32'd1);
    chk({tag, "_busy0"},  32'(bsy0), 32'd0);
    chk({tag, "_done0"},  32'(dn0),  32'd0);
    chk({tag, "_en0"},    32'(en0),  32'd0);
    chk({tag, "_ready1"}, 32'(rdy1), 32'd1);
    chk({tag, "_busy1"},  32'(bsy1), 32'd0);
    chk({tag, "_done1"},  32'(dn1),  32'd0);
    chk({tag, "_en1"},    32'(en1),  32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int idx, input logic en, input logic rw, input logic [2:0] addr,
                     input logic [31:0] wd, input logic dn, input logic rdy, input logic bsy);
    logic [W-1:0] e;
    logic [W-1:0] got;
    int           dc;
    bit           have;
    checks++;
    if (bsy !== !rdy) begin
      failures++;
      $display("FAIL busy_vs_ready dut%0d cyc=%0d busy=%0d ready=%0d", idx, cyc, bsy, rdy);
    end
    if (en === 1'b1) begin
      have = 0;
      if (idx == 0 && exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1; end
      if (idx == 1 && exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1; end
      got = {32'(cyc), rw, addr, rw ? 32'h0 : wd};
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL access_unexpected dut%0d got cyc=%0d rw_=%0d addr=%0d wdata=%h required=none",
                 idx, cyc, rw, addr, wd);
      end else if (got !== e) begin
        failures++;
        $display("FAIL access dut%0d got cyc=%0d rw_=%0d addr=%0d wdata=%h required cyc=%0d rw_=%0d addr=%0d wdata=%h",
                 idx, cyc, rw, addr, wd, e[67:36], e[35], e[34:32], e[31:0]);
      end
    end else begin
      checks++;
      if (en !== 1'b0 || rw !== 1'b1 || addr !== 3'd0 || wd !== 32'h0) begin
        failures++;
        $display("FAIL inactive_port dut%0d cyc=%0d en=%0d rw_=%0d addr=%0d wdata=%h required 0/1/0/0",
                 idx, cyc, en, rw, addr, wd);
      end
    end
    if (dn !== 1'b0) begin
      have = 0;
      dc = 0;
      if (idx == 0 && done_q0.size() != 0) begin dc = done_q0.pop_front(); have = 1; end
      if (idx == 1 && done_q1.size() != 0) begin dc = done_q1.pop_front(); have = 1; end
      checks++;
      if (!have || dc != cyc || dn !== 1'b1) begin
        failures++;
        $display("FAIL done dut%0d got cyc=%0d done=%0d required cyc=%0d (expected=%0d)",
                 idx, cyc, dn, dc, have);
      end
    end
  endtask

  always @(negedge clk) if (started) mon(0, en0, rw0, addr0, wd0, dn0, rdy0, bsy0);
  always @(negedge clk) if (started) mon(1, en1, rw1, addr1, wd1, dn1, rdy1, bsy1);

  // ---------------- main sequence ----------------
  initial begin
    int a;
    int a1;
    int a2;
    logic [31:0] old6;
    logic [31:0] old7;
    logic [31:0] got_st;
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    started     = 0;
    reset       = 1'b1;
    load        = 1'b1;
    cmd_valid   = 1'b0;
    cmd_fill    = 1'b0;
    cmd_src     = '0;
    cmd_dst     = '0;
    cmd_len     = '0;
    cmd_pattern = '0;
    for (int k = 0; k < 4; k++) init_mem[k] = 32'h11 * (k + 1);
    for (int k = 4; k < 8; k++) init_mem[k] = $urandom;
    for (int k = 0; k < 8; k++) model[k] = init_mem[k];
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    load    = 1'b0;
    started = 1;

    // Reset then idle
    repeat (4) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Copy src=0 dst=4 len=4
    issue(1'b0, 0, 4, 4, 32'h0, -1, a);
    drain();
    for (int k = 0; k < 4; k++) begin
      chk("copy_mem0", mem0[4 + k], 32'h11 * (k + 1));
      chk("copy_mem1", mem1[4 + k], 32'h11 * (k + 1));
    end

    // Fill dst=2 len=3
    issue(1'b1, 0, 2, 3, 32'hDEADBEEF, -1, a);
    drain();
    for (int k = 2; k < 5; k++) begin
      chk("fill_mem0", mem0[k], 32'hDEADBEEF);
      chk("fill_mem1", mem1[k], 32'hDEADBEEF);
    end
    chk("fill_untouched0", mem0[1], 32'h22);
    chk("fill_untouched1", mem1[5], 32'h22);

    // Wrap-around copy src=6 dst=0 len=4
    old6 = model[6];
    old7 = model[7];
    issue(1'b0, 6, 0, 4, 32'h0, -1, a);
    drain();
    chk("wrap_a0_dut0", mem0[0], old6);
    chk("wrap_a1_dut0", mem0[1], old7);
    chk("wrap_a2_dut0", mem0[2], old6);
    chk("wrap_a3_dut0", mem0[3], old7);
    chk("wrap_a2_dut1", mem1[2], old6);
    chk("wrap_a3_dut1", mem1[3], old7);

    // len=0 then immediate fill len=1
    issue(1'b0, 3, 3, 0, 32'h0, -1, a1);
    issue(1'b1, 0, 5, 1, 32'hCAFEF00D, -1, a2);
    chk("b2b_accept_cycle", 32'(a2), 32'(a1 + 2));
    drain();

    // Reset during the second READ, with cmd_valid held while busy
    issue(1'b0, 0, 7, 4, 32'h0, 3, a);
    cmd_valid   = 1'b1;
    cmd_fill    = 1'b1;
    cmd_dst     = 3'd3;
    cmd_len     = 4'd2;
    cmd_pattern = 32'h0BADF00D;
    while (cyc < a + 3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    chk("after_reset_rw0",    32'(rw0), 32'd1);
    chk("after_reset_addr1",  32'(addr1), 32'd0);
    chk("after_reset_wdata0", wd0, 32'h0);
    got_st = 32'(st1);
    chk("after_reset_state1", got_st, 32'd0);
    chk("reset_dst0_dut0", mem0[7], model[7]);
    chk("reset_dst0_dut1", mem1[7], model[7]);
    repeat (4) begin
      @(negedge clk);
      check_idle("post_reset_idle");
    end
    drain();

    // Randomized commands, issued back to back
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 8), $urandom, -1, a);
    end
    drain();

    for (int k = 0; k < 8; k++) begin
      chk("final_mem0", mem0[k], model[k]);
      chk("final_mem1", mem1[k], model[k]);
    end
    chk("left_acc0", 32'(exp_q0.size()), 32'd0);
    chk("left_acc1", 32'(exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Single-port initiator that drives one read/write port of the flip-flop RAM to perform block copy and block fill operations. A command (source, destination, length, mode) is accepted over a valid/ready handshake. The engine sequences RAM reads and writes word by word and pulses `done` on completion. It sits between a control master (CPU-side register block or test sequencer) and a single RAM port. It relieves that master of per-word access sequencing.

## Interface
- `DATA`, 32, RAM word width.
- `BYTE`, `DATA`, byte-lane width; must divide `DATA`.
- `DEPTH`, 4, RAM depth; must match the attached RAM.
- `RLAT`, 0, read latency of the attached RAM: 0 = combinational read (OUTREG disabled), 1 = registered read (OUTREG enabled).
- `BYTESEL`, `DATA/BYTE`, constant: number of byte lanes.
- `ADDR`, `$clog2(DEPTH)`, constant: address width.

Ports:
- `clk`  in  1  clock; everything on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine idle; can accept a command.
- `cmd_fill`  in  1  0 = copy, 1 = fill.
- `cmd_src`  in  ADDR  copy source start address; ignored for fill.
- `cmd_dst`  in  ADDR  destination start address.
- `cmd_len`  in  ADDR+1  word count, 0..DEPTH.
- `cmd_pattern`  in  DATA  fill word; ignored for copy.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `ram_en`  out  [BYTESEL]  RAM access enable, per byte lane (all ones when accessing, else zero).
- `ram_rw_`  out  1  1 = read, 0 = write.
- `ram_addr`  out  ADDR  RAM address.
- `ram_wdata`  out  DATA  RAM write data.
- `ram_rdata`  in  DATA  RAM read data.

## Operation
States:
- IDLE.
- READ: issue read at `src+i`.
- WRITE: issue write at `dst+i`.
- DONE: single cycle, pulses `done`.

Accept and dispatch:
- `cmd_ready` = state is IDLE.
- Accept occurs on `cmd_valid && cmd_ready`. Latch src, dst, len, fill and pattern. Word index i = 0.
- Accept with len = 0 goes directly to DONE. No RAM access is made.
- Accept with copy mode goes to READ. Accept with fill mode goes to WRITE.

Copy loop:
- READ → WRITE.
- WRITE → READ if i+1 < len, else DONE. i increments on each WRITE.

Fill loop:
- WRITE → WRITE while i+1 < len, else DONE.

Other transitions:
- DONE → IDLE.

RAM port drive:
- READ: `ram_en`=all ones, `ram_rw_`=1, `ram_addr`=src+i.
- WRITE: `ram_en`=all ones, `ram_rw_`=0, `ram_addr`=dst+i.
- Other states: `ram_en`=0, `ram_rw_`=1, `ram_addr`=0, `ram_wdata`=0.

Write data:
- Fill: `cmd_pattern` as latched.
- Copy, RLAT=0: a holding register captured from `ram_rdata` in READ.
- Copy, RLAT=1: `ram_rdata` directly in WRITE.

Address arithmetic:
- src+i and dst+i are computed modulo 2^ADDR; the carry is dropped.
- For non-power-of-two DEPTH, addresses ≥ DEPTH are the command issuer's responsibility.

Overlap semantics:
- Copies run strictly ascending, each word read-then-written before the next word is read.
- Example: dst = src+1 replicates word src across the whole destination.

Other rules:
- `busy` = state is not IDLE.
- `cmd_valid` while busy is ignored; it is not queued.

## Timing
- Accept at cycle 0. Copy of N words:
  - READ in cycles 1,3,…,2N−1.
  - WRITE in cycles 2,4,…,2N.
  - `done`=1 in cycle 2N+1.
  - `cmd_ready`=1 from cycle 2N+2.
- Fill of N words:
  - WRITE in cycles 1..N.
  - `done` in cycle N+1.
  - Ready in cycle N+2.
- len = 0: `done` in cycle 1, ready in cycle 2.
- Back-to-back: a command presented while `cmd_ready`=1 in cycle 2N+2 is accepted in that cycle.
- Write data visibility:
  - RLAT=0: WRITE data equals the `ram_rdata` sampled at the end of the READ cycle.
  - RLAT=1: WRITE data equals the registered `ram_rdata` presented during the WRITE cycle.
- Reset (any cycle, including mid-command) takes effect in the next cycle:
  - State → IDLE, i → 0.
  - Outputs: `cmd_ready`=1, `busy`=0, `done`=0.
  - RAM port: `ram_en`=0, `ram_rw_`=1, `ram_addr`=0, `ram_wdata`=0.
  - The holding register clears to 0.
  - No partial write is issued in the reset cycle. Words already written remain written.

## Test plan
- Reset then idle, RLAT=0 and RLAT=1:
  - Stimulus: RAM preloaded with 0x11,0x22,0x33,0x44 at addresses 0..3.
  - Required: `cmd_ready`=1, `busy`=0, `done`=0 and `ram_en`=0 in every idle cycle.
- Copy (DEPTH=8), src=0, dst=4, len=4, both RLAT values:
  - Required: addresses 4..7 read 0x11,0x22,0x33,0x44.
  - Required: `done` high only in cycle 9; exactly 8 RAM-active cycles, alternating read/write.
- Fill, dst=2, len=3, pattern=0xDEADBEEF:
  - Required: addresses 2..4 = 0xDEADBEEF; writes in cycles 1..3; `done` in cycle 4; other words unchanged.
- Wrap-around (DEPTH=8), copy src=6, dst=0, len=4:
  - Required: reads at 6,7,0,1; address 0 receives old word 6, address 1 receives old word 7.
  - Required: address 2 receives the new value of address 0 (old word 6), address 3 receives the new value of address 1 (old word 7), per ascending read-then-write semantics.
- len=0 command, then an immediate second fill with len=1:
  - Required: first `done` in cycle 1 with no RAM access.
  - Required: second command accepted in cycle 2, its write in cycle 3, its `done` in cycle 4.
- Reset asserted during copy cycle 3 (second READ) with `cmd_valid` held high while busy:
  - Required: only dst+0 is written; next cycle is idle with all reset values.
  - Required: the busy-time `cmd_valid` is never accepted.
